// File: rtl/mlb_pkg.sv
// Shared helpers and default-derived constants for the multi-line buffer.
package mlb_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned tap_count(input int unsigned num_lines);
        return num_lines + 1;
    endfunction

    function automatic int unsigned fill_count(input int unsigned line_width,
                                               input int unsigned num_lines);
        return line_width * num_lines;
    endfunction

    // LSB position of tap k inside the packed output column
    function automatic int unsigned tap_lsb(input int unsigned k, input int unsigned data_width);
        return k * data_width;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_LINE_WIDTH = 640;
    localparam int unsigned DEF_NUM_LINES  = 2;
    localparam int unsigned DEF_TAPS       = tap_count(DEF_NUM_LINES);
    localparam int unsigned DEF_FILL       = fill_count(DEF_LINE_WIDTH, DEF_NUM_LINES);
    localparam int unsigned DEF_PTR_W      = clog2(DEF_LINE_WIDTH);
    localparam int unsigned DEF_CNT_W      = clog2(DEF_FILL + 1);

endpackage

// File: rtl/mlb_line_ram.sv
// One line delay: single-port, read-before-write memory with combinational read.
module mlb_line_ram
    import mlb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_LINE_WIDTH
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata_c
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Old word is visible before the edge, so it can cascade into the next line
    assign rdata_c = mem[addr];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

endmodule

// File: rtl/multi_line_buffer.sv
// Chained line delays presenting a NUM_LINES+1 pixel column per accepted write.
// Optional MLB_POSITION_EN adds col_o/row_o position outputs.
module multi_line_buffer
    import mlb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  we_i,
    input  logic [DATA_WIDTH-1:0]                 data_i,
    input  logic                                  clear_i,
    output logic [DATA_WIDTH*(NUM_LINES+1)-1:0]   data_o,
    output logic                                  valid_o,
    output logic                                  done_o
`ifdef MLB_POSITION_EN
    ,
    output logic [clog2(LINE_WIDTH)-1:0]          col_o,
    output logic [15:0]                           row_o
`endif
);

    localparam int unsigned TAPS  = tap_count(NUM_LINES);
    localparam int unsigned FILL  = fill_count(LINE_WIDTH, NUM_LINES);
    localparam int unsigned PTR_W = clog2(LINE_WIDTH);
    localparam int unsigned CNT_W = clog2(FILL + 1);
    localparam int unsigned OUT_W = DATA_WIDTH * TAPS;

    logic [PTR_W-1:0]      ptr, ptr_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [OUT_W-1:0]      data_n;
    logic                  valid_n, done_n;
    logic                  accept_c;
    logic                  wrap_c;
    logic [DATA_WIDTH-1:0] wdata [NUM_LINES];
    logic [DATA_WIDTH-1:0] rdata [NUM_LINES];

    assign accept_c = we_i & ~clear_i;
    assign wrap_c   = (ptr == PTR_W'(LINE_WIDTH - 1));

    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign wdata[k] = data_i;
        end else begin : g_chain
            assign wdata[k] = rdata[k-1];
        end

        mlb_line_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (LINE_WIDTH)
        ) u_ram (
            .clk     (clk),
            .we      (accept_c),
            .addr    (ptr),
            .wdata   (wdata[k]),
            .rdata_c (rdata[k])
        );
    end

    // Next-state: clear beats write; idle holds everything except the strobe
    always_comb begin
        ptr_n   = ptr;
        cnt_n   = cnt;
        data_n  = data_o;
        valid_n = 1'b0;
        done_n  = done_o;
        if (clear_i) begin
            ptr_n  = '0;
            cnt_n  = '0;
            data_n = '0;
            done_n = 1'b0;
        end else if (we_i) begin
            ptr_n = wrap_c ? '0 : ptr + PTR_W'(1);
            data_n[DATA_WIDTH-1:0] = data_i;
            for (int k = 0; k < NUM_LINES; k++) begin
                data_n[tap_lsb(k + 1, DATA_WIDTH) +: DATA_WIDTH] = rdata[k];
            end
            if (cnt == CNT_W'(FILL)) valid_n = 1'b1;
            else                     cnt_n   = cnt + CNT_W'(1);
            if (cnt >= CNT_W'(FILL - 1)) done_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            cnt     <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            data_o  <= data_n;
            valid_o <= valid_n;
            done_o  <= done_n;
        end
    end

`ifdef MLB_POSITION_EN
    logic [15:0]      row_cnt, row_cnt_n, row_n;
    logic [PTR_W-1:0] col_n;

    // Position of the slice-0 pixel; row advances after the last column
    always_comb begin
        row_cnt_n = row_cnt;
        row_n     = row_o;
        col_n     = col_o;
        if (clear_i) begin
            row_cnt_n = '0;
            row_n     = '0;
            col_n     = '0;
        end else if (accept_c) begin
            col_n = ptr;
            row_n = row_cnt;
            if (wrap_c) row_cnt_n = row_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt <= '0;
            row_o   <= '0;
            col_o   <= '0;
        end else begin
            row_cnt <= row_cnt_n;
            row_o   <= row_n;
            col_o   <= col_n;
        end
    end
`endif

endmodule

// File: tb/tb_multi_line_buffer.sv
// Directed bench for multi_line_buffer: LW=5/NL=2 instance and LW=4/NL=1 instance.
module tb_multi_line_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [7:0]  data_i = '0;

    logic [23:0] data_a;
    logic        valid_a, done_a;
    logic [15:0] data_b;
    logic        valid_b, done_b;
`ifdef MLB_POSITION_EN
    logic [2:0]  col_a;
    logic [15:0] row_a;
    logic [1:0]  col_b;
    logic [15:0] row_b;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_line_buffer #(.DATA_WIDTH(8), .LINE_WIDTH(5), .NUM_LINES(2)) dut_a (
        .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i), .clear_i(clear_i),
        .data_o(data_a), .valid_o(valid_a), .done_o(done_a)
`ifdef MLB_POSITION_EN
        , .col_o(col_a), .row_o(row_a)
`endif
    );

    multi_line_buffer #(.DATA_WIDTH(8), .LINE_WIDTH(4), .NUM_LINES(1)) dut_b (
        .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i), .clear_i(clear_i),
        .data_o(data_b), .valid_o(valid_b), .done_o(done_b)
`ifdef MLB_POSITION_EN
        , .col_o(col_b), .row_o(row_b)
`endif
    );

    typedef struct {
        logic        we;
        logic        clr;
        logic [7:0]  d;
        logic        ev;
        logic        ed;
        logic        chk_taps;
        logic [23:0] et;
    } vec_t;

    vec_t tv [15];

    function automatic logic [23:0] p3(input int t0, input int t1, input int t2);
        return {8'(t2), 8'(t1), 8'(t0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic clr, input logic [7:0] d);
        we_i    = we;
        clear_i = clr;
        data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        we_i = 1'b0; clear_i = 1'b0; data_i = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int vcount;

        for (int i = 1; i <= 15; i++) begin
            tv[i-1].we       = 1'b1;
            tv[i-1].clr      = 1'b0;
            tv[i-1].d        = 8'(i);
            tv[i-1].ev       = (i >= 11);
            tv[i-1].ed       = (i >= 10);
            tv[i-1].chk_taps = (i >= 11);
            tv[i-1].et       = p3(i, i - 5, i - 10);
        end

        // Reset state
        do_reset();
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);

        // Continuous fill of lines 1..15
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            step(tv[i].we, tv[i].clr, tv[i].d);
            chk($sformatf("t1_valid_w%0d", i + 1), 64'(valid_a), 64'(tv[i].ev));
            chk($sformatf("t1_done_w%0d", i + 1), 64'(done_a), 64'(tv[i].ed));
            chk($sformatf("t1_tap0_w%0d", i + 1), 64'(data_a[7:0]), 64'(tv[i].d));
            if (tv[i].chk_taps)
                chk($sformatf("t1_taps_w%0d", i + 1), 64'(data_a), 64'(tv[i].et));
            if (valid_a) vcount++;
`ifdef MLB_POSITION_EN
            if (i + 1 == 11) begin
                chk("t6_col_w11", 64'(col_a), 64'd0);
                chk("t6_row_w11", 64'(row_a), 64'd2);
            end
            if (i + 1 == 15) begin
                chk("t6_col_w15", 64'(col_a), 64'd4);
                chk("t6_row_w15", 64'(row_a), 64'd2);
            end
`endif
        end
        step(1'b0, 1'b0, 8'd0);
        chk("t1_idle_valid", 64'(valid_a), 64'd0);
        chk("t1_valid_count", 64'(vcount), 64'd5);

        // Idle gap between writes 12 and 13
        do_reset();
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, 8'(i));
        chk("t2_w12_taps", 64'(data_a), 64'(p3(12, 7, 2)));
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 8'hEE);
            chk($sformatf("t2_gap%0d_valid", g), 64'(valid_a), 64'd0);
            chk($sformatf("t2_gap%0d_data", g), 64'(data_a), 64'(p3(12, 7, 2)));
        end
        step(1'b1, 1'b0, 8'd13);
        chk("t2_w13_valid", 64'(valid_a), 64'd1);
        chk("t2_w13_taps", 64'(data_a), 64'(p3(13, 8, 3)));

        // Clear colliding with write 14
        step(1'b1, 1'b1, 8'd14);
        chk("t3_clr_done", 64'(done_a), 64'd0);
        chk("t3_clr_data", 64'(data_a), 64'd0);
        chk("t3_clr_valid", 64'(valid_a), 64'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk($sformatf("t3_refill_valid_w%0d", i), 64'(valid_a), 64'd0);
        end
        chk("t3_refill_done", 64'(done_a), 64'd1);
        step(1'b1, 1'b0, 8'd11);
        chk("t3_w11_valid", 64'(valid_a), 64'd1);
        chk("t3_w11_taps", 64'(data_a), 64'(p3(11, 6, 1)));

        // Asynchronous reset mid-cycle after write 7
        do_reset();
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 8'(i));
        chk("t4_pre_tap0", 64'(data_a[7:0]), 64'd7);
        we_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t4_async_data", 64'(data_a), 64'd0);
        chk("t4_async_valid", 64'(valid_a), 64'd0);
        chk("t4_async_done", 64'(done_a), 64'd0);
        #1 rst = 1'b0;
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'(20 + i));
        chk("t4_w9_done", 64'(done_a), 64'd0);
        step(1'b1, 1'b0, 8'd30);
        chk("t4_w10_done", 64'(done_a), 64'd1);
        chk("t4_w10_valid", 64'(valid_a), 64'd0);

        // Single-line instance, pointer wraps three times
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 8'(i));
            chk($sformatf("t5_valid_w%0d", i), 64'(valid_b), 64'(i >= 5));
            chk($sformatf("t5_done_w%0d", i), 64'(done_b), 64'(i >= 4));
            if (i >= 5)
                chk($sformatf("t5_taps_w%0d", i), 64'(data_b), 64'({8'(i - 4), 8'(i)}));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
